cpu_sequencer: RTL and testbench

Control sequencer that drives the instruction decoder's inputs: owns the fetch/execute state register, the instruction register and the program counter. It consumes the decoder's sequencing outputs (`sm_extra`, `stop`, `pc_sload`, `pc_cnt_en`) and feeds back `state[1:0]` and `instruction[15:0]`. It sits between instruction RAM and the decoder, one per CPU.

---
 rtl/cpu_sequencer_if.sv | 28 ++
 rtl/cpu_sequencer.sv | 84 ++++++++
 tb/tb_cpu_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> instruction RAM / decoder bundle: master is the sequencer, slave is the RAM/decoder side.
// Plain level signals, no handshake; all timing is owned by the sequencer's clock.
interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 12
);
  logic [15:0]         instr_data;
  logic                sm_extra;
  logic                stop;
  logic                pc_sload;
  logic                pc_cnt_en;
  logic [PC_WIDTH-1:0] pc_load_value;
  logic                resume;
  logic [1:0]          state;
  logic [15:0]         instruction;
  logic [PC_WIDTH-1:0] instr_addr;
  logic                halted;
  logic [15:0]         retired;

  modport master (
    input  instr_data, sm_extra, stop, pc_sload, pc_cnt_en, pc_load_value, resume,
    output state, instruction, instr_addr, halted, retired
  );

  modport slave (
    output instr_data, sm_extra, stop, pc_sload, pc_cnt_en, pc_load_value, resume,
    input  state, instruction, instr_addr, halted, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer owning state, IR and PC; 2 cycles per instruction (3 with EXEC2).
// No backpressure: stop parks the machine in HALT until resume with stop low.
module cpu_sequencer #(
  parameter int                  PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  cpu_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b10,
    EXEC2 = 2'b01,
    HALT  = 2'b11
  } state_t;

  state_t              state_q;
  logic [15:0]         ir_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                halted_q;
  logic [15:0]         retired_q;
  logic [PC_WIDTH-1:0] pc_exec_next;

  // Shared by EXEC1 and EXEC2: a load beats an extra increment.
  always_comb begin
    pc_exec_next = pc_q;
    if (bus.pc_sload)
      pc_exec_next = bus.pc_load_value;
    else if (bus.pc_cnt_en)
      pc_exec_next = pc_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      ir_q      <= 16'h0000;
      pc_q      <= RESET_PC;
      halted_q  <= 1'b0;
      retired_q <= 16'h0000;
    end else if (bus.stop) begin
      // Halt edge discards any concurrent PC, IR or retire activity.
      state_q  <= HALT;
      halted_q <= 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          ir_q    <= bus.instr_data;
          pc_q    <= pc_q + 1'b1;
          state_q <= EXEC1;
        end
        EXEC1: begin
          pc_q <= pc_exec_next;
          if (bus.sm_extra) begin
            state_q <= EXEC2;
          end else begin
            state_q   <= FETCH;
            retired_q <= retired_q + 16'd1;
          end
        end
        EXEC2: begin
          pc_q      <= pc_exec_next;
          state_q   <= FETCH;
          retired_q <= retired_q + 16'd1;
        end
        HALT: begin
          if (bus.resume) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.instruction = ir_q;
  assign bus.instr_addr  = pc_q;
  assign bus.halted      = halted_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: plain sequence, EXEC2, jump priority, halt/resume, PC wrap, async reset.
module tb_cpu_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [15:0] ram [0:4095];

  cpu_sequencer_if #(.PC_WIDTH(12)) bus ();

  cpu_sequencer #(.PC_WIDTH(12), .RESET_PC(12'h000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instr_data = ram[bus.instr_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_core(input string tag, input logic [1:0] st, input logic [11:0] pc,
                          input logic [15:0] ret);
    chk({tag, "_state"}, {30'd0, bus.state}, {30'd0, st});
    chk({tag, "_addr"}, {20'd0, bus.instr_addr}, {20'd0, pc});
    chk({tag, "_retired"}, {16'd0, bus.retired}, {16'd0, ret});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
    ram[0]      = 16'h4000;
    ram[1]      = 16'h4800;
    ram[2]      = 16'h6000;
    ram[3]      = 16'h5000;
    ram[4]      = 16'h5800;
    ram[12'h0A5] = 16'h7123;
    ram[12'hFFF] = 16'hBEEF;

    reset             = 1'b1;
    bus.sm_extra      = 1'b0;
    bus.stop          = 1'b0;
    bus.pc_sload      = 1'b0;
    bus.pc_cnt_en     = 1'b0;
    bus.pc_load_value = 12'h000;
    bus.resume        = 1'b0;

    #12;
    chk_core("rst", 2'b00, 12'h000, 16'd0);
    chk("rst_ir", {16'd0, bus.instruction}, 32'h0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    reset = 1'b0;

    // Plain sequence of three single-phase instructions
    step(); chk_core("seq_e1a", 2'b10, 12'h001, 16'd0);
    chk("seq_ir_a", {16'd0, bus.instruction}, 32'h4000);
    step(); chk_core("seq_f_b", 2'b00, 12'h001, 16'd1);
    step(); chk_core("seq_e1b", 2'b10, 12'h002, 16'd1);
    chk("seq_ir_b", {16'd0, bus.instruction}, 32'h4800);
    step(); chk_core("seq_f_c", 2'b00, 12'h002, 16'd2);
    step(); chk_core("seq_e1c", 2'b10, 12'h003, 16'd2);
    chk("seq_ir_c", {16'd0, bus.instruction}, 32'h6000);
    step(); chk_core("seq_done", 2'b00, 12'h003, 16'd3);

    // Extra phase
    step(); chk_core("x_e1", 2'b10, 12'h004, 16'd3);
    bus.sm_extra = 1'b1;
    step(); chk_core("x_e2", 2'b01, 12'h004, 16'd3);
    bus.sm_extra = 1'b0;
    step(); chk_core("x_done", 2'b00, 12'h004, 16'd4);

    // Jump with load and skip both asserted
    step(); chk_core("j_e1", 2'b10, 12'h005, 16'd4);
    bus.pc_sload      = 1'b1;
    bus.pc_cnt_en     = 1'b1;
    bus.pc_load_value = 12'h0A5;
    step(); chk_core("j_fetch", 2'b00, 12'h0A5, 16'd5);
    bus.pc_sload  = 1'b0;
    bus.pc_cnt_en = 1'b0;
    step(); chk_core("j_after", 2'b10, 12'h0A6, 16'd5);
    chk("j_ir", {16'd0, bus.instruction}, 32'h7123);

    // Stop in EXEC2 overrides a pending load
    bus.sm_extra = 1'b1;
    step(); chk_core("s_e2", 2'b01, 12'h0A6, 16'd5);
    bus.stop          = 1'b1;
    bus.pc_sload      = 1'b1;
    bus.pc_load_value = 12'h123;
    step(); chk_core("s_halt", 2'b11, 12'h0A6, 16'd5);
    chk("s_halted", {31'd0, bus.halted}, 32'd1);
    chk("s_ir_hold", {16'd0, bus.instruction}, 32'h7123);
    bus.sm_extra = 1'b0;
    bus.pc_sload = 1'b0;
    bus.resume   = 1'b1;
    step(); chk_core("s_res_blk", 2'b11, 12'h0A6, 16'd5);
    chk("s_halted2", {31'd0, bus.halted}, 32'd1);
    bus.stop = 1'b0;
    step(); chk_core("s_resumed", 2'b00, 12'h0A6, 16'd5);
    chk("s_unhalted", {31'd0, bus.halted}, 32'd0);
    bus.resume = 1'b0;

    // Skip-only increment
    step(); chk_core("k_e1", 2'b10, 12'h0A7, 16'd5);
    bus.pc_cnt_en = 1'b1;
    step(); chk_core("k_fetch", 2'b00, 12'h0A8, 16'd6);
    bus.pc_cnt_en = 1'b0;

    // PC wrap from FFF
    step(); chk_core("w_e1", 2'b10, 12'h0A9, 16'd6);
    bus.pc_sload      = 1'b1;
    bus.pc_load_value = 12'hFFF;
    step(); chk_core("w_fetch", 2'b00, 12'hFFF, 16'd7);
    bus.pc_sload = 1'b0;
    step(); chk_core("w_wrap", 2'b10, 12'h000, 16'd7);
    chk("w_ir", {16'd0, bus.instruction}, 32'hBEEF);

    // Stop in FETCH: no IR load, no PC increment
    step(); chk_core("f_fetch", 2'b00, 12'h000, 16'd8);
    bus.stop = 1'b1;
    step(); chk_core("f_halt", 2'b11, 12'h000, 16'd8);
    chk("f_ir_hold", {16'd0, bus.instruction}, 32'hBEEF);
    bus.stop   = 1'b0;
    bus.resume = 1'b1;
    step(); chk_core("f_resumed", 2'b00, 12'h000, 16'd8);
    bus.resume = 1'b0;

    // Asynchronous reset mid-EXEC1
    step(); chk_core("r_e1", 2'b10, 12'h001, 16'd8);
    chk("r_ir", {16'd0, bus.instruction}, 32'h4000);
    #2;
    reset = 1'b1;
    #1;
    chk_core("r_async", 2'b00, 12'h000, 16'd0);
    chk("r_async_ir", {16'd0, bus.instruction}, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    chk_core("r_release", 2'b00, 12'h000, 16'd0);
    step(); chk_core("r_refetch", 2'b10, 12'h001, 16'd0);
    chk("r_refetch_ir", {16'd0, bus.instruction}, 32'h4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
